// File: rtl/druaga_pkg.sv
// Shared definitions for the Druaga download/load controller.
//   load_state_t : controller states (HOLD, LOAD, RUN)
//   IDX_ROM      : hps_io download index carrying the ROM image
//   IDX_TNO      : hps_io download index carrying the title number byte
package druaga_pkg;

  typedef enum logic [1:0] {
    HOLD,
    LOAD,
    RUN
  } load_state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_TNO = 8'd1;

endpackage

// File: rtl/load_settle_timer.sv
// Loadable down-counter that times the settle window in which the game core
// is kept in reset after a download or reset request.
// Ports:
//   clk_sys : system clock
//   reset   : synchronous active-high reset (reloads the counter)
//   load    : reload to the full settle window
//   enable  : count down (controller is in HOLD)
//   done    : high during the last cycle of the window
module load_settle_timer #(
  parameter int unsigned SETTLE_CYC = 1024
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic done
);

  localparam int unsigned CW = $clog2(SETTLE_CYC);
  localparam logic [CW-1:0] START = CW'(SETTLE_CYC - 1);

  logic [CW-1:0] count;

  // Reloading sets the equivalent of an up-count of zero; reaching zero here
  // corresponds to the up-count reaching SETTLE_CYC-1.
  always_ff @(posedge clk_sys) begin
    if (reset || load) begin
      count <= START;
    end else if (enable && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = enable && !load && (count == '0);

endmodule

// File: rtl/druaga_load_ctrl.sv
// Sequencing controller between the hps_io download port and the Druaga game
// core: forwards ROM bytes during a download, latches the title number, holds
// the core in reset through download plus a settle window, and checks the
// downloaded image size.
// Optional feature macro: DRUAGA_LOAD_CSUM_EN (running checksum on csum).
// Ports:
//   clk_sys, RESET              : clock and synchronous active-high reset
//   rst_req                     : OSD/button reset request (level)
//   ioctl_download/wr/addr/dout/index : hps_io download interface
//   rom_wr, rom_addr, rom_data  : registered write port to the core ROMs
//   tno                         : latched title number (0 = none)
//   core_reset                  : reset to the game core
//   load_done                   : a correctly sized image has been loaded
//   size_err                    : last download had the wrong byte count
//   csum                        : checksum of forwarded bytes (0 if disabled)
module druaga_load_ctrl
  import druaga_pkg::*;
#(
  parameter int unsigned AW         = 17,
  parameter int unsigned ROM_BYTES  = 17'h1_0000,
  parameter int unsigned SETTLE_CYC = 1024
) (
  input  logic          clk_sys,
  input  logic          RESET,
  input  logic          rst_req,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic [7:0]    ioctl_index,
  output logic          rom_wr,
  output logic [AW-1:0] rom_addr,
  output logic [7:0]    rom_data,
  output logic [3:0]    tno,
  output logic          core_reset,
  output logic          load_done,
  output logic          size_err,
  output logic [7:0]    csum
);

  localparam logic [24:0] ROM_LIMIT = 25'(ROM_BYTES);
  localparam logic [AW:0] ROM_COUNT = (AW+1)'(ROM_BYTES);

  load_state_t   state;
  logic          download_q;
  logic [AW:0]   byte_cnt;
  logic          settle_done;

  logic dl_rise;
  logic dl_fall;
  logic wr_rom;
  logic wr_fwd;
  logic wr_tno;

  assign dl_rise = ioctl_download && !download_q;
  assign dl_fall = !ioctl_download && download_q;
  assign wr_rom  = (state == LOAD) && ioctl_wr && (ioctl_index == IDX_ROM);
  assign wr_fwd  = wr_rom && (ioctl_addr < ROM_LIMIT);
  assign wr_tno  = (state == LOAD) && ioctl_wr && (ioctl_index == IDX_TNO);

  // The timer is held at its full window everywhere except HOLD, so HOLD is
  // always entered with a fresh window; rst_req in HOLD restarts it.
  load_settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_settle (
    .clk_sys(clk_sys),
    .reset  (RESET),
    .load   ((state != HOLD) || rst_req),
    .enable (state == HOLD),
    .done   (settle_done)
  );

  // Controller FSM with registered core_reset and image status flags.
  // download_q reloads from the live input on RESET so a download that is
  // still high afterwards is not mistaken for a new rising edge.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state      <= HOLD;
      core_reset <= 1'b1;
      download_q <= ioctl_download;
      size_err   <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      download_q <= ioctl_download;
      if (dl_rise) begin
        state      <= LOAD;
        core_reset <= 1'b1;
      end else begin
        case (state)
          LOAD: begin
            if (dl_fall) begin
              state     <= HOLD;
              size_err  <= (byte_cnt != ROM_COUNT);
              load_done <= load_done | (byte_cnt == ROM_COUNT);
            end
          end
          HOLD: begin
            if (settle_done) begin
              state      <= RUN;
              core_reset <= 1'b0;
            end
          end
          RUN: begin
            if (rst_req) begin
              state      <= HOLD;
              core_reset <= 1'b1;
            end
          end
          default: begin
            state      <= HOLD;
            core_reset <= 1'b1;
          end
        endcase
      end
    end
  end

  // Write forwarding, title latch and saturating byte counter.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      rom_wr   <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
      tno      <= '0;
      byte_cnt <= '0;
    end else begin
      rom_wr <= wr_fwd;
      if (wr_fwd) begin
        rom_addr <= ioctl_addr[AW-1:0];
        rom_data <= ioctl_dout;
      end
      if (wr_tno) begin
        tno <= ioctl_dout[3:0];
      end
      if (dl_rise) begin
        byte_cnt <= '0;
      end else if (wr_rom && byte_cnt != '1) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

`ifdef DRUAGA_LOAD_CSUM_EN
  logic [7:0] csum_q;

  // Modulo-256 sum of forwarded bytes, updated alongside rom_wr.
  always_ff @(posedge clk_sys) begin
    if (RESET || dl_rise) begin
      csum_q <= 8'h00;
    end else if (wr_fwd) begin
      csum_q <= csum_q + ioctl_dout;
    end
  end

  assign csum = csum_q;
`else
  assign csum = 8'h00;
`endif

endmodule
